// File: rtl/ocp_slave_fsm.sv
// ocp_slave_fsm: single-beat OCP 3.0 responder bridging the OCP bus onto a
// simple memory-side port. WR is posted, RD returns DVA + SData, and every
// other MCmd is accepted and answered with ERR.
// Optional feature macro: OCP_SLAVE_TIMEOUT_EN bounds the backend wait to
// TIMEOUT_CYCLES enabled cycles.
module ocp_slave_fsm #(
  parameter int ADDR_WDTH      = 64,
  parameter int DATA_WDTH      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 Clk,
  input  logic                 MReset_n,
  input  logic                 EnableClk,
  input  logic [ADDR_WDTH-1:0] MAddr,
  input  logic [2:0]           MCmd,
  input  logic [DATA_WDTH-1:0] MData,
  input  logic                 MRespAccept,
  output logic                 SCmdAccept,
  output logic [1:0]           SResp,
  output logic [DATA_WDTH-1:0] SData,
  output logic [ADDR_WDTH-1:0] mem_addr,
  output logic [DATA_WDTH-1:0] mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [DATA_WDTH-1:0] mem_rdata,
  input  logic                 mem_ready
);

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;

  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t state;

  // Reject configurations where the timeout could never be reached sensibly.
  if (TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("ocp_slave_fsm: TIMEOUT_CYCLES must be >= 2");
  end

`ifdef OCP_SLAVE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tmo_cnt;
`endif

  // Request accept is only possible while idle, enabled and out of reset.
  always_comb begin
    SCmdAccept = (state == S_IDLE) & EnableClk & MReset_n;
  end

  // Main FSM with registered OCP response and memory-side outputs.
  always_ff @(posedge Clk or negedge MReset_n) begin
    if (!MReset_n) begin
      state     <= S_IDLE;
      SResp     <= RESP_NULL;
      SData     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
`ifdef OCP_SLAVE_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else if (EnableClk) begin
      case (state)
        S_IDLE: begin
`ifdef OCP_SLAVE_TIMEOUT_EN
          // Held at zero while idle so it is clear on entry to S_WR/S_RD.
          tmo_cnt <= '0;
`endif
          case (MCmd)
            CMD_IDLE: ;
            CMD_WR: begin
              mem_addr  <= MAddr;
              mem_wdata <= MData;
              mem_we    <= 1'b1;
              state     <= S_WR;
            end
            CMD_RD: begin
              mem_addr <= MAddr;
              mem_re   <= 1'b1;
              state    <= S_RD;
            end
            default: begin
              SResp <= RESP_ERR;
              SData <= '0;
              state <= S_RESP;
            end
          endcase
        end

        S_WR: begin
          if (mem_ready) begin
            mem_we <= 1'b0;
            state  <= S_IDLE;
          end
`ifdef OCP_SLAVE_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            mem_we <= 1'b0;
            state  <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
`endif
        end

        S_RD: begin
          if (mem_ready) begin
            mem_re <= 1'b0;
            SData  <= mem_rdata;
            SResp  <= RESP_DVA;
            state  <= S_RESP;
          end
`ifdef OCP_SLAVE_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            mem_re <= 1'b0;
            SData  <= '0;
            SResp  <= RESP_ERR;
            state  <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
`endif
        end

        S_RESP: begin
          if (MRespAccept) begin
            SResp <= RESP_NULL;
            SData <= '0;
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ocp_slave_fsm.sv
// tb_ocp_slave_fsm: directed bench for ocp_slave_fsm. Inputs are driven 1ns
// after the rising edge and outputs are sampled at that same point.
module tb_ocp_slave_fsm;

  logic        Clk;
  logic        MReset_n;
  logic        EnableClk;
  logic [63:0] MAddr;
  logic [2:0]  MCmd;
  logic [7:0]  MData;
  logic        MRespAccept;
  logic        SCmdAccept;
  logic [1:0]  SResp;
  logic [7:0]  SData;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  ocp_slave_fsm #(
    .ADDR_WDTH      (64),
    .DATA_WDTH      (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .Clk         (Clk),
    .MReset_n    (MReset_n),
    .EnableClk   (EnableClk),
    .MAddr       (MAddr),
    .MCmd        (MCmd),
    .MData       (MData),
    .MRespAccept (MRespAccept),
    .SCmdAccept  (SCmdAccept),
    .SResp       (SResp),
    .SData       (SData),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    tests_run++;
    if ({SResp, SData, mem_we, mem_re, SCmdAccept} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_outs: got %0h expected 0", {SResp, SData, mem_we, mem_re, SCmdAccept});
    end
    tests_run++;
    if ({mem_addr, mem_wdata} !== 72'd0) begin
      tests_failed++;
      $display("FAIL reset_mem: got %0h expected 0", {mem_addr, mem_wdata});
    end
    MReset_n = 1'b1;
    #1;
    tests_run++;
    if (SCmdAccept !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_accept: got %0b expected 1", SCmdAccept);
    end
    tick();
  endtask

  task automatic test_write();
    MCmd = 3'd1; MAddr = 64'h10; MData = 8'hA5;
    #1;
    tests_run++;
    if (SCmdAccept !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_accept: got %0b expected 1", SCmdAccept);
    end
    tick();
    MCmd = 3'd0; MAddr = 64'hFF; MData = 8'h00;
    #1;
    tests_run++;
    if ({mem_we, mem_re, SCmdAccept, SResp} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL wr_strobe: got %b expected 10000", {mem_we, mem_re, SCmdAccept, SResp});
    end
    tests_run++;
    if (mem_addr !== 64'h10 || mem_wdata !== 8'hA5) begin
      tests_failed++;
      $display("FAIL wr_latch: got %0h/%0h expected 10/a5", mem_addr, mem_wdata);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tests_run++;
    if ({mem_we, SCmdAccept, SResp} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL wr_done: got %b expected 0100", {mem_we, SCmdAccept, SResp});
    end
    tests_run++;
    if (mem_addr !== 64'h10 || mem_wdata !== 8'hA5) begin
      tests_failed++;
      $display("FAIL wr_hold: got %0h/%0h expected 10/a5", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_read();
    MCmd = 3'd2; MAddr = 64'h20;
    tick();
    MCmd = 3'd0;
    tests_run++;
    if ({mem_re, mem_we, SCmdAccept, SResp} !== 5'b10000 || mem_addr !== 64'h20) begin
      tests_failed++;
      $display("FAIL rd_strobe: got %b addr %0h expected 10000 addr 20", {mem_re, mem_we, SCmdAccept, SResp}, mem_addr);
    end
    mem_rdata = 8'h3C; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_rdata = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (SResp !== 2'd1 || SData !== 8'h3C || mem_re !== 1'b0 || SCmdAccept !== 1'b0) begin
        tests_failed++;
        $display("FAIL rd_dva_hold[%0d]: got resp %0d data %0h re %0b acc %0b expected 1 3c 0 0", i, SResp, SData, mem_re, SCmdAccept);
      end
      if (i < 2) tick();
    end
    MRespAccept = 1'b1;
    tick();
    MRespAccept = 1'b0;
    tests_run++;
    if (SResp !== 2'd0 || SData !== 8'h00 || SCmdAccept !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_release: got resp %0d data %0h acc %0b expected 0 0 1", SResp, SData, SCmdAccept);
    end
  endtask

  task automatic test_err_cmds();
    for (int c = 3; c <= 7; c++) begin
      MCmd = 3'(c);
      tick();
      MCmd = 3'd0;
      tick();
      tests_run++;
      if (SResp !== 2'd3 || SData !== 8'h00 || mem_re !== 1'b0 || mem_we !== 1'b0 || SCmdAccept !== 1'b0) begin
        tests_failed++;
        $display("FAIL err_cmd%0d: got resp %0d data %0h re %0b we %0b acc %0b expected 3 0 0 0 0", c, SResp, SData, mem_re, mem_we, SCmdAccept);
      end
      MRespAccept = 1'b1;
      tick();
      MRespAccept = 1'b0;
      tests_run++;
      if (SResp !== 2'd0 || SCmdAccept !== 1'b1) begin
        tests_failed++;
        $display("FAIL err_release%0d: got resp %0d acc %0b expected 0 1", c, SResp, SCmdAccept);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    mem_ready = 1'b1; MRespAccept = 1'b1;
    repeat (2) tick();
    mem_ready = 1'b0; MRespAccept = 1'b0;
    tests_run++;
    if ({mem_we, mem_re, SResp, SCmdAccept} !== 5'b00001) begin
      tests_failed++;
      $display("FAIL idle_ignore: got %b expected 00001", {mem_we, mem_re, SResp, SCmdAccept});
    end
  endtask

  task automatic test_enable();
    MCmd = 3'd2; MAddr = 64'h30;
    tick();
    MCmd = 3'd0;
    EnableClk = 1'b0; mem_ready = 1'b1; mem_rdata = 8'h5A;
    repeat (4) tick();
    tests_run++;
    if (SResp !== 2'd0 || mem_re !== 1'b1 || SCmdAccept !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_freeze: got resp %0d re %0b acc %0b expected 0 1 0", SResp, mem_re, SCmdAccept);
    end
    EnableClk = 1'b1;
    tick();
    mem_ready = 1'b0;
    tests_run++;
    if (SResp !== 2'd1 || SData !== 8'h5A || mem_re !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_resume: got resp %0d data %0h re %0b expected 1 5a 0", SResp, SData, mem_re);
    end
    // Frozen in S_RESP: MRespAccept with the clock disabled must not release.
    EnableClk = 1'b0; MRespAccept = 1'b1;
    tick();
    tests_run++;
    if (SResp !== 2'd1 || SCmdAccept !== 1'b0) begin
      tests_failed++;
      $display("FAIL en_resp_freeze: got resp %0d acc %0b expected 1 0", SResp, SCmdAccept);
    end
    EnableClk = 1'b1;
    tick();
    MRespAccept = 1'b0;
  endtask

  task automatic test_reset_mid_resp();
    MCmd = 3'd2; MAddr = 64'h40;
    tick();
    MCmd = 3'd0; mem_ready = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_ready = 1'b0;
    #2 MReset_n = 1'b0;
    #1;
    tests_run++;
    if (SResp !== 2'd0 || SData !== 8'h00 || mem_addr !== 64'h0 || SCmdAccept !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got resp %0d data %0h addr %0h acc %0b expected 0 0 0 0", SResp, SData, mem_addr, SCmdAccept);
    end
    MReset_n = 1'b1;
    tick();
    tests_run++;
    if (SResp !== 2'd0 || SCmdAccept !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset: got resp %0d acc %0b expected 0 1", SResp, SCmdAccept);
    end
  endtask

`ifdef OCP_SLAVE_TIMEOUT_EN
  task automatic test_timeout();
    MCmd = 3'd2; MAddr = 64'h50;
    tick();
    MCmd = 3'd0;
    repeat (15) tick();
    tests_run++;
    if (SResp !== 2'd0 || mem_re !== 1'b1) begin
      tests_failed++;
      $display("FAIL tmo_rd_early: got resp %0d re %0b expected 0 1", SResp, mem_re);
    end
    tick();
    tests_run++;
    if (SResp !== 2'd3 || SData !== 8'h00 || mem_re !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_rd: got resp %0d data %0h re %0b expected 3 0 0", SResp, SData, mem_re);
    end
    MRespAccept = 1'b1;
    tick();
    MRespAccept = 1'b0;
    MCmd = 3'd1; MAddr = 64'h60; MData = 8'h11;
    tick();
    MCmd = 3'd0;
    repeat (15) tick();
    tests_run++;
    if (mem_we !== 1'b1 || SCmdAccept !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_wr_early: got we %0b acc %0b expected 1 0", mem_we, SCmdAccept);
    end
    tick();
    tests_run++;
    if (mem_we !== 1'b0 || SCmdAccept !== 1'b1 || SResp !== 2'd0) begin
      tests_failed++;
      $display("FAIL tmo_wr: got we %0b acc %0b resp %0d expected 0 1 0", mem_we, SCmdAccept, SResp);
    end
  endtask
`else
  task automatic test_no_timeout();
    MCmd = 3'd2; MAddr = 64'h50;
    tick();
    MCmd = 3'd0;
    repeat (40) tick();
    tests_run++;
    if (SResp !== 2'd0 || mem_re !== 1'b1 || SCmdAccept !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_tmo_wait: got resp %0d re %0b acc %0b expected 0 1 0", SResp, mem_re, SCmdAccept);
    end
    mem_rdata = 8'h99; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tests_run++;
    if (SResp !== 2'd1 || SData !== 8'h99) begin
      tests_failed++;
      $display("FAIL no_tmo_done: got resp %0d data %0h expected 1 99", SResp, SData);
    end
    MRespAccept = 1'b1;
    tick();
    MRespAccept = 1'b0;
  endtask
`endif

  initial begin
    MReset_n = 1'b0; EnableClk = 1'b1; MAddr = '0; MCmd = 3'd0; MData = '0;
    MRespAccept = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_err_cmds();
    test_ignored_inputs();
    test_enable();
    test_reset_mid_resp();
`ifdef OCP_SLAVE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
